// File: rtl/clock_period_meter.sv
// Period and high-time meter for a slow square wave, counted in CLOCK_IN cycles.
// state | meaning
// IDLE  | waiting for the first rising edge (after reset or a timeout)
// RUN   | measuring; each rising edge publishes PERIOD/HIGH_TIME
module clock_period_meter #(
  parameter int unsigned      WIDTH      = 28,
  parameter logic [WIDTH-1:0] MAX_CYCLES = 28'd50000000
) (
  input  logic             CLOCK_IN,
  input  logic             RESET_N,
  input  logic             SIG_IN,
  output logic [WIDTH-1:0] PERIOD,
  output logic [WIDTH-1:0] HIGH_TIME,
  output logic             VALID,
  output logic             LOCKED,
  output logic             TIMEOUT
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0] LAST = MAX_CYCLES - ONE;

  state_t           state;
  state_t           state_nxt;
  logic             s1;
  logic             s2;
  logic             s3;
  logic             rise;
  logic [WIDTH-1:0] pcnt;
  logic [WIDTH-1:0] pcnt_nxt;
  logic [WIDTH-1:0] hcnt;
  logic [WIDTH-1:0] hcnt_nxt;
  logic [WIDTH-1:0] period_nxt;
  logic [WIDTH-1:0] high_nxt;
  logic             valid_nxt;
  logic             timeout_nxt;

  // s1/s2 resynchronise SIG_IN; s3 is the delayed copy for edge detection
  always_ff @(posedge CLOCK_IN or negedge RESET_N) begin
    if (!RESET_N) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= SIG_IN;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;

  always_comb begin
    state_nxt   = state;
    pcnt_nxt    = pcnt;
    hcnt_nxt    = hcnt;
    period_nxt  = PERIOD;
    high_nxt    = HIGH_TIME;
    valid_nxt   = 1'b0;
    timeout_nxt = TIMEOUT;
    case (state)
      IDLE: begin
        if (rise) begin
          pcnt_nxt    = '0;
          hcnt_nxt    = ONE;
          timeout_nxt = 1'b0;
          state_nxt   = RUN;
        end
      end
      RUN: begin
        pcnt_nxt = pcnt + ONE;
        hcnt_nxt = hcnt + WIDTH'(s2);
        // a rise on the last allowed cycle still counts as a measurement
        if (rise) begin
          period_nxt = pcnt + ONE;
          high_nxt   = hcnt;
          valid_nxt  = 1'b1;
          pcnt_nxt   = '0;
          hcnt_nxt   = ONE;
        end else if (pcnt == LAST) begin
          timeout_nxt = 1'b1;
          state_nxt   = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_IN or negedge RESET_N) begin
    if (!RESET_N) begin
      state     <= IDLE;
      pcnt      <= '0;
      hcnt      <= '0;
      PERIOD    <= '0;
      HIGH_TIME <= '0;
      VALID     <= 1'b0;
      LOCKED    <= 1'b0;
      TIMEOUT   <= 1'b0;
    end else begin
      state     <= state_nxt;
      pcnt      <= pcnt_nxt;
      hcnt      <= hcnt_nxt;
      PERIOD    <= period_nxt;
      HIGH_TIME <= high_nxt;
      VALID     <= valid_nxt;
      LOCKED    <= (state_nxt == RUN);
      TIMEOUT   <= timeout_nxt;
    end
  end

endmodule

// File: tb/tb_clock_period_meter.sv
// Directed bench for clock_period_meter with MAX_CYCLES = 100.
module tb_clock_period_meter;

  localparam int W = 28;

  typedef struct {
    int           stp;
    logic [W-1:0] p;
    logic [W-1:0] h;
  } meas_t;

  logic         CLOCK_IN;
  logic         RESET_N;
  logic         SIG_IN;
  logic [W-1:0] PERIOD;
  logic [W-1:0] HIGH_TIME;
  logic         VALID;
  logic         LOCKED;
  logic         TIMEOUT;

  int    tests_run;
  int    tests_failed;
  int    stepn;
  int    to_first;
  meas_t vq[$];

  clock_period_meter #(.WIDTH(W), .MAX_CYCLES(28'd100)) dut (
    .CLOCK_IN (CLOCK_IN),
    .RESET_N  (RESET_N),
    .SIG_IN   (SIG_IN),
    .PERIOD   (PERIOD),
    .HIGH_TIME(HIGH_TIME),
    .VALID    (VALID),
    .LOCKED   (LOCKED),
    .TIMEOUT  (TIMEOUT)
  );

  initial CLOCK_IN = 1'b0;
  always #5 CLOCK_IN = ~CLOCK_IN;

  // one CLOCK_IN cycle: drive SIG_IN, clock it in, observe 1 ns after the edge
  task automatic step(input logic v);
    meas_t m;
    SIG_IN = v;
    @(posedge CLOCK_IN);
    #1;
    stepn++;
    if (VALID) begin
      m.stp = stepn;
      m.p   = PERIOD;
      m.h   = HIGH_TIME;
      vq.push_back(m);
    end
    if (TIMEOUT && to_first == 0) to_first = stepn;
  endtask

  task automatic wave(input int hi, input int lo, input int nper);
    for (int p = 0; p < nper; p++) begin
      for (int i = 0; i < hi; i++) step(1'b1);
      for (int i = 0; i < lo; i++) step(1'b0);
    end
  endtask

  task automatic do_reset();
    SIG_IN  = 1'b0;
    RESET_N = 1'b0;
    #1;
    repeat (2) @(posedge CLOCK_IN);
    #1;
    RESET_N  = 1'b1;
    stepn    = 0;
    to_first = 0;
    vq.delete();
  endtask

  task automatic test_reset();
    SIG_IN  = 1'b0;
    RESET_N = 1'b0;
    repeat (3) @(posedge CLOCK_IN);
    #1;
    tests_run++;
    if ({PERIOD, HIGH_TIME} !== '0) begin
      tests_failed++;
      $display("FAIL reset_results: PERIOD=%0d HIGH_TIME=%0d expected 0/0", PERIOD, HIGH_TIME);
    end
    tests_run++;
    if ({VALID, LOCKED, TIMEOUT} !== 3'b000) begin
      tests_failed++;
      $display("FAIL reset_flags: V/L/T=%b expected 000", {VALID, LOCKED, TIMEOUT});
    end
  endtask

  task automatic test_square_2_2();
    do_reset();
    step(1'b1);
    step(1'b1);
    tests_run++;
    if (LOCKED !== 1'b0) begin
      tests_failed++;
      $display("FAIL lock_early: LOCKED=%b expected 0 after 2 edges", LOCKED);
    end
    step(1'b0);
    tests_run++;
    if ({LOCKED, VALID} !== 2'b10) begin
      tests_failed++;
      $display("FAIL lock_first_rise: LOCKED,VALID=%b expected 10", {LOCKED, VALID});
    end
    step(1'b0);
    wave(2, 2, 5);
    tests_run++;
    if (vq.size() !== 5) begin
      tests_failed++;
      $display("FAIL sq22_count: got %0d VALIDs expected 5", vq.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        tests_run++;
        if (vq[i].stp !== 7 + 4 * i || vq[i].p !== 28'd4 || vq[i].h !== 28'd2) begin
          tests_failed++;
          $display("FAIL sq22_meas[%0d]: step=%0d P=%0d H=%0d expected step=%0d P=4 H=2",
                   i, vq[i].stp, vq[i].p, vq[i].h, 7 + 4 * i);
        end
      end
    end
  endtask

  task automatic test_change_rate();
    do_reset();
    wave(3, 2, 4);
    wave(1, 1, 4);
    step(1'b0);
    step(1'b0);
    tests_run++;
    if (vq.size() !== 7) begin
      tests_failed++;
      $display("FAIL rate_count: got %0d VALIDs expected 7", vq.size());
    end else begin
      tests_run++;
      if (vq[0].stp !== 8 || vq[0].p !== 28'd5 || vq[0].h !== 28'd3) begin
        tests_failed++;
        $display("FAIL rate_32: step=%0d P=%0d H=%0d expected step=8 P=5 H=3", vq[0].stp, vq[0].p, vq[0].h);
      end
      tests_run++;
      if (vq[3].stp !== 23 || vq[3].p !== 28'd5 || vq[3].h !== 28'd3) begin
        tests_failed++;
        $display("FAIL rate_transition: step=%0d P=%0d H=%0d expected step=23 P=5 H=3", vq[3].stp, vq[3].p, vq[3].h);
      end
      tests_run++;
      if (vq[4].stp !== 25 || vq[4].p !== 28'd2 || vq[4].h !== 28'd1) begin
        tests_failed++;
        $display("FAIL rate_11_first: step=%0d P=%0d H=%0d expected step=25 P=2 H=1", vq[4].stp, vq[4].p, vq[4].h);
      end
      tests_run++;
      if (vq[6].stp !== 29 || vq[6].p !== 28'd2 || vq[6].h !== 28'd1) begin
        tests_failed++;
        $display("FAIL rate_11_last: step=%0d P=%0d H=%0d expected step=29 P=2 H=1", vq[6].stp, vq[6].p, vq[6].h);
      end
    end
  endtask

  task automatic test_timeout();
    do_reset();
    wave(2, 2, 3);
    while (stepn < 110) step(1'b0);
    tests_run++;
    if ({TIMEOUT, LOCKED} !== 2'b01) begin
      tests_failed++;
      $display("FAIL to_early: TIMEOUT,LOCKED=%b expected 01 at step 110", {TIMEOUT, LOCKED});
    end
    step(1'b0);
    tests_run++;
    if ({TIMEOUT, LOCKED, VALID} !== 3'b100 || to_first !== 111) begin
      tests_failed++;
      $display("FAIL to_assert: T/L/V=%b first_timeout_step=%0d expected 100 at 111",
               {TIMEOUT, LOCKED, VALID}, to_first);
    end
    tests_run++;
    if (PERIOD !== 28'd4 || HIGH_TIME !== 28'd2 || vq.size() !== 2) begin
      tests_failed++;
      $display("FAIL to_hold: P=%0d H=%0d valids=%0d expected 4/2/2", PERIOD, HIGH_TIME, vq.size());
    end
    step(1'b1);
    step(1'b1);
    tests_run++;
    if (TIMEOUT !== 1'b1) begin
      tests_failed++;
      $display("FAIL to_sticky: TIMEOUT=%b expected 1 before rise is acted on", TIMEOUT);
    end
    step(1'b0);
    tests_run++;
    if ({TIMEOUT, LOCKED, VALID} !== 3'b010) begin
      tests_failed++;
      $display("FAIL to_clear: T/L/V=%b expected 010 at step 114", {TIMEOUT, LOCKED, VALID});
    end
    step(1'b0);
    wave(2, 2, 2);
    tests_run++;
    if (vq.size() !== 4) begin
      tests_failed++;
      $display("FAIL to_resume_count: got %0d VALIDs expected 4", vq.size());
    end else begin
      tests_run++;
      if (vq[2].stp !== 118 || vq[2].p !== 28'd4 || vq[2].h !== 28'd2) begin
        tests_failed++;
        $display("FAIL to_resume_meas: step=%0d P=%0d H=%0d expected step=118 P=4 H=2", vq[2].stp, vq[2].p, vq[2].h);
      end
    end
  endtask

  task automatic test_boundary();
    do_reset();
    wave(50, 50, 3);
    tests_run++;
    if (vq.size() !== 2 || to_first !== 0 || LOCKED !== 1'b1) begin
      tests_failed++;
      $display("FAIL p100_status: valids=%0d timeout_step=%0d LOCKED=%b expected 2/0/1", vq.size(), to_first, LOCKED);
    end else begin
      tests_run++;
      if (vq[0].stp !== 103 || vq[0].p !== 28'd100 || vq[0].h !== 28'd50) begin
        tests_failed++;
        $display("FAIL p100_meas: step=%0d P=%0d H=%0d expected step=103 P=100 H=50", vq[0].stp, vq[0].p, vq[0].h);
      end
    end
    do_reset();
    wave(50, 51, 3);
    tests_run++;
    if (to_first !== 103 || vq.size() !== 0) begin
      tests_failed++;
      $display("FAIL p101: timeout_step=%0d valids=%0d expected 103/0", to_first, vq.size());
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    wave(2, 2, 2);
    step(1'b1);
    tests_run++;
    if (LOCKED !== 1'b1 || PERIOD !== 28'd4) begin
      tests_failed++;
      $display("FAIL ar_pre: LOCKED=%b P=%0d expected 1/4", LOCKED, PERIOD);
    end
    RESET_N = 1'b0;
    #1;
    tests_run++;
    if ({PERIOD, HIGH_TIME, VALID, LOCKED, TIMEOUT} !== '0) begin
      tests_failed++;
      $display("FAIL ar_immediate: P=%0d H=%0d V/L/T=%b expected all 0",
               PERIOD, HIGH_TIME, {VALID, LOCKED, TIMEOUT});
    end
    do_reset();
    wave(3, 2, 3);
    tests_run++;
    if (vq.size() !== 2) begin
      tests_failed++;
      $display("FAIL ar_count: got %0d VALIDs expected 2", vq.size());
    end else begin
      tests_run++;
      if (vq[0].stp !== 8 || vq[0].p !== 28'd5 || vq[0].h !== 28'd3) begin
        tests_failed++;
        $display("FAIL ar_meas: step=%0d P=%0d H=%0d expected step=8 P=5 H=3", vq[0].stp, vq[0].p, vq[0].h);
      end
    end
  endtask

  task automatic test_stuck_high();
    do_reset();
    repeat (3) step(1'b1);
    tests_run++;
    if (LOCKED !== 1'b1) begin
      tests_failed++;
      $display("FAIL stuck_lock: LOCKED=%b expected 1", LOCKED);
    end
    repeat (147) step(1'b1);
    tests_run++;
    if (to_first !== 103 || vq.size() !== 0 || {TIMEOUT, LOCKED} !== 2'b10) begin
      tests_failed++;
      $display("FAIL stuck_timeout: timeout_step=%0d valids=%0d T,L=%b expected 103/0/10",
               to_first, vq.size(), {TIMEOUT, LOCKED});
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    stepn        = 0;
    to_first     = 0;
    RESET_N      = 1'b0;
    SIG_IN       = 1'b0;
    test_reset();
    test_square_2_2();
    test_change_rate();
    test_timeout();
    test_boundary();
    test_async_reset();
    test_stuck_high();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
